// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic pipeline boundary registers:
//     - pipe_state_t        : occupancy state of a pipeline_skid_reg
//     - PIPE_CNT_W_DEFAULT  : default width of the performance counters
//     - stage payload structs, which stages cast to the DATA_W payload vector
//       of the boundary register they drive
//   No ports. This is a package.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy of the boundary register:
  //   EMPTY : no entry held
  //   FULL  : main entry only
  //   SKID  : main entry plus one skid entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int PIPE_CNT_W_DEFAULT = 32;

  // Payload carried across the execute -> memory boundary.
  typedef struct packed {
    logic [1:0]  result_src;
    logic        mem_we;
    logic        reg_we;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [2:0]  func3;
    logic [3:0]  cause;
    logic [4:0]  rd_addr;
  } mem_stage_t;

  localparam int MEM_STAGE_W = $bits(mem_stage_t);

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
//   Saturating up-counter used for pipeline performance statistics. It
//   advances by one on every clock edge where inc is high and stops at
//   all-ones rather than wrapping. Only reset clears it.
//
//   Parameters:
//     CNT_W   : counter width in bits
//   Ports:
//     i_clk    in   1      clock, rising edge
//     i_arst_n in   1      asynchronous active-low reset (clears count)
//     i_inc    in   1      count this cycle
//     o_cnt    out  CNT_W  current count, registered
// -----------------------------------------------------------------------------
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic at_max;

  assign at_max = &o_cnt;

  // NOTE: state is updated with non-blocking (<=) assignments so every flop
  // samples the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_cnt <= '0;
    end else if (i_inc && !at_max) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule : pipe_sat_counter

// File: rtl/pipeline_skid_reg.sv
// -----------------------------------------------------------------------------
// pipeline_skid_reg
//   Elastic pipeline register for an inter-stage boundary. Both sides use a
//   valid/ready handshake. A two-entry skid buffer (main + skid) lets o_ready
//   come straight from a flop, so there is no combinational path from i_ready
//   to o_ready. Ordering is strict FIFO: main is always presented first and
//   the skid entry moves into main when main drains.
//
//   Parameters:
//     DATA_W        : payload width (>= 1); stages pack their struct into it
//     RESET_PAYLOAD : 1 = payload flops reset to 0, 0 = payload flops unreset
//     CNT_W         : performance counter width
//
//   Build option:
//     PIPE_PERF_CNT_EN : when defined, o_stall_cnt / o_bubble_cnt are
//                        saturating counters. Otherwise both are tied to 0
//                        and no counter flops exist.
//
//   Ports:
//     i_clk        in   1       clock, rising edge
//     i_arst_n     in   1       asynchronous active-low reset
//     i_flush      in   1       synchronous kill of all held entries
//     i_valid      in   1       upstream payload valid
//     i_data       in   DATA_W  upstream payload
//     o_ready      out  1       can accept (registered)
//     o_valid      out  1       downstream payload valid (registered)
//     o_data       out  DATA_W  downstream payload, from main entry
//     i_ready      in   1       downstream accepts
//     o_stall_cnt  out  CNT_W   cycles with o_valid=1 and i_ready=0
//     o_bubble_cnt out  CNT_W   cycles with o_valid=0
// -----------------------------------------------------------------------------
module pipeline_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter bit RESET_PAYLOAD = 1'b1,
  parameter int CNT_W         = PIPE_CNT_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pipe_state_t       state, state_nxt;
  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_dat, skid_dat;
  logic [DATA_W-1:0] main_dat_nxt, skid_dat_nxt;

  logic in_fire;
  logic out_fire;
  logic main_load;       // main <= i_data
  logic main_from_skid;  // main <= skid (skid drains into main)
  logic skid_load;       // skid <= i_data

  assign o_valid = main_vld;
  assign o_ready = ~skid_vld;
  assign o_data  = main_dat;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = main_vld & i_ready;

  // ---------------------------------------------------------------------------
  // Next-state and payload steering
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; otherwise a path
  // that does not assign it would hold its old value and infer a latch.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;

    if (i_flush) begin
      // Flush beats everything: held entries die and any incoming beat is
      // dropped. A beat leaving this cycle has already gone downstream.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = FULL;
            main_load = 1'b1;
          end
        end

        FULL: begin
          unique case ({in_fire, out_fire})
            2'b11: main_load = 1'b1;
            2'b10: begin
              state_nxt = SKID;
              skid_load = 1'b1;
            end
            2'b01: state_nxt = EMPTY;
            default: ;
          endcase
        end

        SKID: begin
          // o_ready is low here, so nothing can enter.
          if (out_fire) begin
            state_nxt      = FULL;
            main_from_skid = 1'b1;
          end
        end

        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_dat_nxt = main_dat;
    skid_dat_nxt = skid_dat;
    if (main_load) begin
      main_dat_nxt = i_data;
    end else if (main_from_skid) begin
      main_dat_nxt = skid_dat;
    end
    if (skid_load) begin
      skid_dat_nxt = i_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control flops: always reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= EMPTY;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      main_vld <= (state_nxt != EMPTY);
      skid_vld <= (state_nxt == SKID);
    end
  end

  // ---------------------------------------------------------------------------
  // Payload flops: reset is optional
  // ---------------------------------------------------------------------------
  // NOTE: the valid bits alone say whether an entry means anything, so wide
  // payload flops may go without reset. They then come up undefined, which
  // is harmless because nothing consumes them while the valid bits are low.
  generate
    if (RESET_PAYLOAD) begin : g_payload_rst
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
          main_dat <= '0;
          skid_dat <= '0;
        end else begin
          main_dat <= main_dat_nxt;
          skid_dat <= skid_dat_nxt;
        end
      end
    end else begin : g_payload_norst
      always_ff @(posedge i_clk) begin
        main_dat <= main_dat_nxt;
        skid_dat <= skid_dat_nxt;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  // A flush cycle counts by the o_valid/i_ready seen before the flush.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_inc    (main_vld & ~i_ready),
    .o_cnt    (o_stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_inc    (~main_vld),
    .o_cnt    (o_bubble_cnt)
  );
`else
  assign o_stall_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Invariant: a stalled output beat must hold its payload.
  // ---------------------------------------------------------------------------
  a_data_hold : assert property (
    @(posedge i_clk) disable iff (!i_arst_n)
      (o_valid && !i_ready) |=> $stable(o_data)
  );

endmodule : pipeline_skid_reg

// File: tb/tb_pipeline_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipeline_skid_reg
//   Self-checking bench for pipeline_skid_reg with DATA_W=8 and CNT_W=4.
//   A table of single-cycle vectors covers streaming, the skid path and
//   flush. Hand-written sequences cover asynchronous reset mid-burst and the
//   performance counters. When PIPE_PERF_CNT_EN is not defined, the counter
//   checks expect 0.
// -----------------------------------------------------------------------------
module tb_pipeline_skid_reg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam bit RP     = 1'b1;

  logic              i_clk;
  logic              i_arst_n;
  logic              i_flush;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_bubble_cnt;

  pipeline_skid_reg #(
    .DATA_W        (DATA_W),
    .RESET_PAYLOAD (RP),
    .CNT_W         (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Hold reset over two edges, then release just after an edge so that the
  // next edge is the first one seen out of reset.
  task automatic do_reset();
    i_arst_n = 1'b0;
    i_flush  = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b1;
    tick();
    tick();
    i_arst_n = 1'b1;
  endtask

  // One row: inputs applied for one edge, then outputs expected after it.
  typedef struct {
    logic             valid;
    logic [7:0]       data;
    logic             ready;
    logic             flush;
    logic             exp_valid;
    logic             exp_ready;
    logic [7:0]       exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic r, input logic f,
                     input logic ev, input logic er, input logic [7:0] ed);
    vec_t t;
    t.valid = v;  t.data = d;  t.ready = r;  t.flush = f;
    t.exp_valid = ev;  t.exp_ready = er;  t.exp_data = ed;
    vecs.push_back(t);
  endtask

  logic [CNT_W-1:0] exp_stall3, exp_bubble3, exp_stall20, exp_bubble20;

  initial begin
    // ---------------- vector table ----------------
    // Back-to-back streaming with i_ready=1: each beat shows one edge later.
    for (int k = 1; k <= 16; k++) add(1, 8'(k), 1, 0, 1, 1, 8'(k));
    add(0, 8'h00, 1, 0, 0, 1, 8'h10);
    // Backpressure: A1 to main, A2 to skid, A3 held upstream.
    add(1, 8'hA1, 0, 0, 1, 1, 8'hA1);
    add(1, 8'hA2, 0, 0, 1, 0, 8'hA1);
    add(1, 8'hA3, 0, 0, 1, 0, 8'hA1);
    add(1, 8'h5A, 0, 0, 1, 0, 8'hA1);  // i_data wiggles while o_ready=0
    add(0, 8'h00, 0, 0, 1, 0, 8'hA1);  // i_valid drops without transfer
    add(1, 8'hA3, 1, 0, 1, 1, 8'hA2);  // skid drains into main
    add(1, 8'hA3, 1, 0, 1, 1, 8'hA3);
    add(0, 8'h00, 1, 0, 0, 1, 8'hA3);
    // Flush in SKID with a simultaneous upstream beat 0xEE.
    add(1, 8'hB1, 0, 0, 1, 1, 8'hB1);
    add(1, 8'hB2, 0, 0, 1, 0, 8'hB1);
    add(1, 8'hEE, 0, 1, 0, 1, 8'hB1);
    add(0, 8'h00, 1, 0, 0, 1, 8'hB1);
    add(1, 8'hC1, 1, 0, 1, 1, 8'hC1);
    add(0, 8'h00, 1, 0, 0, 1, 8'hC1);
    // Flush in FULL with both in_fire and out_fire: incoming D2 is dropped.
    add(1, 8'hD1, 0, 0, 1, 1, 8'hD1);
    add(1, 8'hD2, 1, 1, 0, 1, 8'hD1);
    add(0, 8'h00, 1, 0, 0, 1, 8'hD1);

    // ---------------- reset state ----------------
    do_reset();
    check("rst o_valid", 32'(o_valid), 32'd0);
    check("rst o_ready", 32'(o_ready), 32'd1);
    if (RP) check("rst o_data", 32'(o_data), 32'h0);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      i_valid = vecs[i].valid;
      i_data  = vecs[i].data;
      i_ready = vecs[i].ready;
      i_flush = vecs[i].flush;
      tick();
      check($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d o_ready", i), 32'(o_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d o_data", i), 32'(o_data), 32'(vecs[i].exp_data));
    end
    i_flush = 1'b0;
    i_valid = 1'b0;

    // ---------------- reset mid-burst while in SKID ----------------
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h11; tick();
    i_valid = 1'b1; i_data = 8'h22; tick();
    check("burst skid o_ready", 32'(o_ready), 32'd0);
    #2;
    i_arst_n = 1'b0;
    #1;
    check("async rst o_valid", 32'(o_valid), 32'd0);
    check("async rst o_ready", 32'(o_ready), 32'd1);
    if (RP) check("async rst o_data", 32'(o_data), 32'h0);
    check("async rst stall_cnt", 32'(o_stall_cnt), 32'd0);
    check("async rst bubble_cnt", 32'(o_bubble_cnt), 32'd0);
    i_valid = 1'b0;
    tick();
    i_arst_n = 1'b1;
    i_ready  = 1'b1;
    i_valid  = 1'b1; i_data = 8'h33;
    tick();
    check("post rst o_valid", 32'(o_valid), 32'd1);
    check("post rst o_data", 32'(o_data), 32'h33);
    i_valid = 1'b0;
    tick();
    check("post rst drain", 32'(o_valid), 32'd0);

    // ---------------- performance counters ----------------
`ifdef PIPE_PERF_CNT_EN
    exp_bubble3 = 4'd3;  exp_stall3  = 4'd0;
    exp_bubble20 = 4'd4; exp_stall20 = 4'd15;
`else
    exp_bubble3 = 4'd0;  exp_stall3  = 4'd0;
    exp_bubble20 = 4'd0; exp_stall20 = 4'd0;
`endif
    do_reset();
    i_ready = 1'b1;
    i_valid = 1'b0;
    repeat (3) tick();
    check("perf bubble 3 idle", 32'(o_bubble_cnt), 32'(exp_bubble3));
    check("perf stall 3 idle", 32'(o_stall_cnt), 32'(exp_stall3));
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h55;
    tick();                       // bubble edge 4, beat enters main
    i_valid = 1'b0;
    repeat (20) tick();           // 20 stalled edges, saturates at 15
    check("perf stall sat", 32'(o_stall_cnt), 32'(exp_stall20));
    check("perf bubble after stall", 32'(o_bubble_cnt), 32'(exp_bubble20));
    check("perf stalled data", 32'(o_data), 32'h55);
    // Flush does not clear the counters.
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("perf flush keeps stall", 32'(o_stall_cnt), 32'(exp_stall20));
    check("perf flush o_valid", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_skid_reg
